// File: rtl/fetch_if.sv
// Fetch unit bus bundle: control from the pipeline, the instruction memory
// request/response pair and the IF/ID slot presented to decode.
//   master : fetch unit side (drives imem_req/imem_addr and the IF/ID slot)
//   slave  : environment side (pipeline control and instruction memory)
interface fetch_if;
    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 5;

    logic            stall;
    logic            flush;
    logic [XLEN-1:0] branch_target;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_rdata;
    logic [XLEN-1:0] if_id_pc;
    logic [XLEN-1:0] if_id_inst;
    logic            if_id_valid;
    logic [OPW-1:0]  opcode;

    modport master (
        input  stall, flush, branch_target, imem_ready, imem_rdata,
        output imem_req, imem_addr, if_id_pc, if_id_inst, if_id_valid, opcode
    );

    modport slave (
        output stall, flush, branch_target, imem_ready, imem_rdata,
        input  imem_req, imem_addr, if_id_pc, if_id_inst, if_id_valid, opcode
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage with a one-entry hold buffer for stalls.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : fetch_if.master -- stall/flush/branch_target in, imem request and
//          response, IF/ID slot (pc, inst, valid) and decoded opcode out
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);
    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] hold_q, hold_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [XLEN-1:0] if_inst_q, if_inst_d;
    logic            if_valid_q, if_valid_d;
    logic [XLEN-1:0] pc_inc;

    // pc+4 wraps naturally in 32 bits
    assign pc_inc = pc_q + XLEN'(4);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC & ALIGN_MASK;
            hold_q     <= '0;
            if_pc_q    <= '0;
            if_inst_q  <= NOP_INST;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hold_q     <= hold_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
        end
    end

    // Next-state and datapath update; flush beats stall beats imem_ready
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_d     = hold_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if_valid_d = if_valid_q;

        if (bus.flush) begin
            // Redirect: drop any same-cycle response and any held word
            state_d    = FETCH;
            pc_d       = bus.branch_target & ALIGN_MASK;
            if_pc_d    = '0;
            if_inst_d  = NOP_INST;
            if_valid_d = 1'b0;
        end else if (bus.stall) begin
            // IF/ID frozen; park a response that arrives during the stall
            if (state_q == FETCH && bus.imem_ready) begin
                hold_d  = bus.imem_rdata;
                state_d = HOLD;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (bus.imem_ready) begin
                        if_inst_d  = bus.imem_rdata;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        pc_d       = pc_inc;
                    end else begin
                        if_inst_d  = NOP_INST;
                        if_valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if_inst_d  = hold_q;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    pc_d       = pc_inc;
                    state_d    = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // Request is suppressed in the reset cycle so a stale fetch never issues
    assign bus.imem_req    = (state_q == FETCH) && !rst;
    assign bus.imem_addr   = pc_q;
    assign bus.if_id_pc    = if_pc_q;
    assign bus.if_id_inst  = if_inst_q;
    assign bus.if_id_valid = if_valid_q;
    assign bus.opcode      = if_inst_q[6:2];
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, bubbles, stall/hold,
// flush priority, pc wrap and reset while holding.
module tb_fetch_unit;
    logic        clk;
    logic        rst;
    logic        tag_mode;
    logic [31:0] fixed_word;
    int          checks;
    int          failures;

    fetch_if bus ();

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Memory returns an address-tagged word, or a fixed word when tag_mode=0
    assign bus.imem_rdata = tag_mode ? (bus.imem_addr ^ 32'hA500_0000) : fixed_word;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_slot(input string tag, input logic [31:0] pc,
                              input logic [31:0] inst, input logic valid);
        check({tag, ".pc"},    bus.if_id_pc, pc);
        check({tag, ".inst"},  bus.if_id_inst, inst);
        check({tag, ".valid"}, 32'(bus.if_id_valid), 32'(valid));
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        rst               = 1'b1;
        tag_mode          = 1'b1;
        fixed_word        = 32'h0;
        bus.stall         = 1'b0;
        bus.flush         = 1'b0;
        bus.branch_target = 32'h0;
        bus.imem_ready    = 1'b1;

        // Reset state (rst still high, ready high: no request)
        step();
        check_slot("rst", 32'h0, 32'h0000_0013, 1'b0);
        check("rst.req",    32'(bus.imem_req), 32'd0);
        check("rst.addr",   bus.imem_addr, 32'h0);
        check("rst.opcode", 32'(bus.opcode), 32'h04);

        rst = 1'b0;
        #1;
        check("run.req", 32'(bus.imem_req), 32'd1);

        // Sequential fetch
        step();
        check_slot("seq0", 32'h0, 32'hA500_0000, 1'b1);
        check("seq0.addr", bus.imem_addr, 32'h4);
        step();
        check_slot("seq4", 32'h4, 32'hA500_0004, 1'b1);
        check("seq4.addr", bus.imem_addr, 32'h8);

        // Three bubbles with imem_ready low at pc=8
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bub.valid",  32'(bus.if_id_valid), 32'd0);
            check("bub.inst",   bus.if_id_inst, 32'h0000_0013);
            check("bub.opcode", 32'(bus.opcode), 32'h04);
            check("bub.addr",   bus.imem_addr, 32'h8);
            check("bub.req",    32'(bus.imem_req), 32'd1);
        end

        bus.imem_ready = 1'b1;
        step();
        check_slot("seq8", 32'h8, 32'hA500_0008, 1'b1);
        check("seq8.addr", bus.imem_addr, 32'hC);

        // Stall two cycles while the word at pc=C arrives
        tag_mode   = 1'b0;
        fixed_word = 32'h00A0_0093;
        bus.stall  = 1'b1;
        step();
        check("hold1.req", 32'(bus.imem_req), 32'd0);
        check_slot("hold1", 32'h8, 32'hA500_0008, 1'b1);
        fixed_word = 32'hDEAD_BEEF;
        step();
        check("hold2.req", 32'(bus.imem_req), 32'd0);
        check_slot("hold2", 32'h8, 32'hA500_0008, 1'b1);

        bus.stall      = 1'b0;
        bus.imem_ready = 1'b0;
        step();
        check_slot("rel", 32'hC, 32'h00A0_0093, 1'b1);
        check("rel.addr", bus.imem_addr, 32'h10);
        check("rel.req",  32'(bus.imem_req), 32'd1);

        // Flush coincident with ready and stall
        bus.flush         = 1'b1;
        bus.stall         = 1'b1;
        bus.imem_ready    = 1'b1;
        bus.branch_target = 32'h0000_0102;
        step();
        check("fl.addr", bus.imem_addr, 32'h0000_0100);
        check("fl.req",  32'(bus.imem_req), 32'd1);
        check_slot("fl", 32'h0, 32'h0000_0013, 1'b0);

        bus.flush      = 1'b0;
        bus.stall      = 1'b0;
        bus.imem_ready = 1'b0;
        step();
        check_slot("fl.after", 32'h0, 32'h0000_0013, 1'b0);
        check("fl.after.addr", bus.imem_addr, 32'h0000_0100);

        // Branch to the top of the address space and wrap
        bus.flush         = 1'b1;
        bus.branch_target = 32'hFFFF_FFFC;
        step();
        check("wrap.target", bus.imem_addr, 32'hFFFF_FFFC);
        bus.flush      = 1'b0;
        bus.imem_ready = 1'b1;
        tag_mode       = 1'b1;
        step();
        check_slot("wrap", 32'hFFFF_FFFC, 32'h5AFF_FFFC, 1'b1);
        check("wrap.addr", bus.imem_addr, 32'h0);

        // Enter HOLD, then reset while holding
        bus.stall = 1'b1;
        step();
        check("rh.req", 32'(bus.imem_req), 32'd0);
        rst = 1'b1;
        step();
        check("rh.rst.req",  32'(bus.imem_req), 32'd0);
        check("rh.rst.addr", bus.imem_addr, 32'h0);
        check_slot("rh.rst", 32'h0, 32'h0000_0013, 1'b0);

        rst            = 1'b0;
        bus.stall      = 1'b0;
        bus.imem_ready = 1'b0;
        #1;
        check("rh.fetch.req", 32'(bus.imem_req), 32'd1);
        step();
        check_slot("rh.nohold", 32'h0, 32'h0000_0013, 1'b0);
        check("rh.nohold.addr", bus.imem_addr, 32'h0);

        bus.imem_ready = 1'b1;
        step();
        check_slot("rh.refetch", 32'h0, 32'hA500_0000, 1'b1);
        check("rh.refetch.addr", bus.imem_addr, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
